// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encodings are common to the D-stage and E-stage selectors.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    MEMWAIT
  } memwait_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // $zero is hardwired, so a match on register 0 is never a real dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hz_fwd_sel.sv
// Per-operand forwarding selector: picks the M ALU result over the W result,
// and never forwards a load still sitting in M.
module hz_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_addr_i,
  input  logic [4:0] m_rd_i,
  input  logic       m_regwrite_i,
  input  logic       m_memread_i,
  input  logic [4:0] w_rd_i,
  input  logic       w_regwrite_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (m_regwrite_i && !m_memread_i && reg_match(src_addr_i, m_rd_i)) begin
      sel_o = FWD_M;
    end else if (w_regwrite_i && reg_match(src_addr_i, w_rd_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core, plus a memory-wait freeze FSM,
// saturating stall/flush counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MEM_TO = 255
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic [4:0]       i_addr_Drs,
  input  logic [4:0]       i_addr_Drt,
  input  logic             i_con_Duse_rs,
  input  logic             i_con_Duse_rt,
  input  logic             i_con_Dbranch,
  input  logic             i_con_Dredirect,
  input  logic [4:0]       i_addr_Ers,
  input  logic [4:0]       i_addr_Ert,
  input  logic [4:0]       i_addr_Erd,
  input  logic             i_con_Eregwrite,
  input  logic             i_con_Ememread,
  input  logic [4:0]       i_addr_Mrd,
  input  logic             i_con_Mregwrite,
  input  logic             i_con_Mmemread,
  input  logic [4:0]       i_addr_Wrd,
  input  logic             i_con_Wregwrite,
  input  logic             i_con_Mmemreq,
  input  logic             i_con_Mmemack,
  output logic             o_con_Fstall,
  output logic             o_con_Dstall,
  output logic             o_con_Dflush,
  output logic             o_con_Eflush,
  output logic             o_con_freeze,
  output logic             o_con_Dfwd_rs,
  output logic             o_con_Dfwd_rt,
  output logic [1:0]       o_con_Efwd_rs,
  output logic [1:0]       o_con_Efwd_rt,
  output logic [CNT_W-1:0] o_stat_stalls,
  output logic [CNT_W-1:0] o_stat_flushes,
  output logic             o_stat_memto
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TO);

  memwait_state_t    state_q, state_d;
  logic [CNT_W-1:0]  stalls_q, stalls_d;
  logic [CNT_W-1:0]  flushes_q, flushes_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              memto_q, memto_d;

  logic [1:0] dsel_rs, dsel_rt;
  logic       use_rs_hit_e, use_rt_hit_e;
  logic       load_use, branch_hz, hazard;

  hz_fwd_sel u_dfwd_rs (
    .src_addr_i(i_addr_Drs), .m_rd_i(i_addr_Mrd), .m_regwrite_i(i_con_Mregwrite),
    .m_memread_i(i_con_Mmemread), .w_rd_i(i_addr_Wrd), .w_regwrite_i(1'b0), .sel_o(dsel_rs)
  );
  hz_fwd_sel u_dfwd_rt (
    .src_addr_i(i_addr_Drt), .m_rd_i(i_addr_Mrd), .m_regwrite_i(i_con_Mregwrite),
    .m_memread_i(i_con_Mmemread), .w_rd_i(i_addr_Wrd), .w_regwrite_i(1'b0), .sel_o(dsel_rt)
  );
  hz_fwd_sel u_efwd_rs (
    .src_addr_i(i_addr_Ers), .m_rd_i(i_addr_Mrd), .m_regwrite_i(i_con_Mregwrite),
    .m_memread_i(i_con_Mmemread), .w_rd_i(i_addr_Wrd), .w_regwrite_i(i_con_Wregwrite),
    .sel_o(o_con_Efwd_rs)
  );
  hz_fwd_sel u_efwd_rt (
    .src_addr_i(i_addr_Ert), .m_rd_i(i_addr_Mrd), .m_regwrite_i(i_con_Mregwrite),
    .m_memread_i(i_con_Mmemread), .w_rd_i(i_addr_Wrd), .w_regwrite_i(i_con_Wregwrite),
    .sel_o(o_con_Efwd_rt)
  );

  // The decode comparator only ever takes the M ALU result; W is already in the regfile.
  assign o_con_Dfwd_rs = (dsel_rs == FWD_M);
  assign o_con_Dfwd_rt = (dsel_rt == FWD_M);

  assign use_rs_hit_e = i_con_Duse_rs && reg_match(i_addr_Drs, i_addr_Erd);
  assign use_rt_hit_e = i_con_Duse_rt && reg_match(i_addr_Drt, i_addr_Erd);
  assign load_use     = i_con_Ememread && (use_rs_hit_e || use_rt_hit_e);
  assign branch_hz    = i_con_Dbranch && (
      (i_con_Eregwrite && (use_rs_hit_e || use_rt_hit_e)) ||
      (i_con_Mmemread && i_con_Mregwrite &&
        ((i_con_Duse_rs && reg_match(i_addr_Drs, i_addr_Mrd)) ||
         (i_con_Duse_rt && reg_match(i_addr_Drt, i_addr_Mrd)))));
  assign hazard       = load_use || branch_hz;

  // Freeze wins over hazards and redirects; a redirect caught by freeze stays held in D.
  always_comb begin
    state_d      = state_q;
    o_con_freeze = 1'b0;
    o_con_Fstall = 1'b0;
    o_con_Dstall = 1'b0;
    o_con_Dflush = 1'b0;
    o_con_Eflush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (i_con_Mmemreq && !i_con_Mmemack) begin
          state_d      = MEMWAIT;
          o_con_freeze = 1'b1;
        end
      end
      MEMWAIT: begin
        o_con_freeze = 1'b1;
        if (i_con_Mmemack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (o_con_freeze) begin
      o_con_Fstall = 1'b1;
      o_con_Dstall = 1'b1;
    end else if (hazard) begin
      o_con_Fstall = 1'b1;
      o_con_Dstall = 1'b1;
      o_con_Eflush = 1'b1;
    end else if (i_con_Dredirect) begin
      o_con_Dflush = 1'b1;
    end
  end

  always_comb begin
    stalls_d  = stalls_q;
    flushes_d = flushes_q;
    wait_d    = wait_q;
    if (o_con_Fstall && (stalls_q != '1)) stalls_d = stalls_q + CNT_W'(1);
    if ((o_con_Dflush || o_con_Eflush) && (flushes_q != '1)) flushes_d = flushes_q + CNT_W'(1);
    if (state_q == RUN && state_d == MEMWAIT) begin
      wait_d = '0;
    end else if (state_q == MEMWAIT && wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    memto_d = memto_q || (state_q == MEMWAIT && wait_d == WAIT_MAX);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= RUN;
      stalls_q  <= '0;
      flushes_q <= '0;
      wait_q    <= '0;
      memto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
      wait_q    <= wait_d;
      memto_q   <= memto_d;
    end
  end

  assign o_stat_stalls  = stalls_q;
  assign o_stat_flushes = flushes_q;
  assign o_stat_memto   = memto_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a queue,
// a monitor pops and compares one entry per cycle on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int MEM_TO = 4;

  // Control bundle order: {Fstall, Dstall, Dflush, Eflush, freeze, Dfwd_rs, Dfwd_rt}
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] STALL  = 7'b1101000;
  localparam logic [6:0] FLUSHD = 7'b0010000;
  localparam logic [6:0] FRZ    = 7'b1100100;
  localparam logic [6:0] DFRS   = 7'b0000010;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [1:0]       efwdRs;
    logic [1:0]       efwdRt;
    logic [CNT_W-1:0] stalls;
    logic [CNT_W-1:0] flushes;
    logic             memto;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  logic [4:0] dRs, dRt, eRs, eRt, eRd, mRd, wRd;
  logic dUseRs, dUseRt, dBranch, dRedirect, eRegwrite, eMemread;
  logic mRegwrite, mMemread, wRegwrite, memReq, memAck;
  logic fStall, dStall, dFlush, eFlush, freeze, dFwdRs, dFwdRt, memto;
  logic [1:0] eFwdRs, eFwdRt;
  logic [CNT_W-1:0] statStalls, statFlushes;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    fails  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_addr_Drs(dRs), .i_addr_Drt(dRt),
    .i_con_Duse_rs(dUseRs), .i_con_Duse_rt(dUseRt),
    .i_con_Dbranch(dBranch), .i_con_Dredirect(dRedirect),
    .i_addr_Ers(eRs), .i_addr_Ert(eRt), .i_addr_Erd(eRd),
    .i_con_Eregwrite(eRegwrite), .i_con_Ememread(eMemread),
    .i_addr_Mrd(mRd), .i_con_Mregwrite(mRegwrite), .i_con_Mmemread(mMemread),
    .i_addr_Wrd(wRd), .i_con_Wregwrite(wRegwrite),
    .i_con_Mmemreq(memReq), .i_con_Mmemack(memAck),
    .o_con_Fstall(fStall), .o_con_Dstall(dStall), .o_con_Dflush(dFlush),
    .o_con_Eflush(eFlush), .o_con_freeze(freeze),
    .o_con_Dfwd_rs(dFwdRs), .o_con_Dfwd_rt(dFwdRt),
    .o_con_Efwd_rs(eFwdRs), .o_con_Efwd_rt(eFwdRt),
    .o_stat_stalls(statStalls), .o_stat_flushes(statFlushes), .o_stat_memto(memto)
  );

  function automatic exp_t mkExp(input logic [6:0] ctl, input logic [1:0] ers,
                                 input logic [1:0] ert, input int s, input int f,
                                 input logic m);
    exp_t e;
    e.ctl = ctl; e.efwdRs = ers; e.efwdRt = ert;
    e.stalls = CNT_W'(s); e.flushes = CNT_W'(f); e.memto = m;
    return e;
  endfunction

  task automatic clearInputs();
    nrst = 1'b1;
    dRs = 0; dRt = 0; eRs = 0; eRt = 0; eRd = 0; mRd = 0; wRd = 0;
    dUseRs = 0; dUseRt = 0; dBranch = 0; dRedirect = 0; eRegwrite = 0; eMemread = 0;
    mRegwrite = 0; mMemread = 0; wRegwrite = 0; memReq = 0; memAck = 0;
  endtask

  // Inputs are already set; queue the expectation and hold them for one cycle.
  task automatic applyStimulus(input string name, input exp_t e);
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act.ctl     = {fStall, dStall, dFlush, eFlush, freeze, dFwdRs, dFwdRt};
    act.efwdRs  = eFwdRs;
    act.efwdRt  = eFwdRt;
    act.stalls  = statStalls;
    act.flushes = statFlushes;
    act.memto   = memto;
    checks++;
    if (act !== e) begin
      fails++;
      $display("[TB] FAIL %s: got ctl=%b efwd=%b/%b stalls=%0d flushes=%0d memto=%b, expected ctl=%b efwd=%b/%b stalls=%0d flushes=%0d memto=%b",
               name, act.ctl, act.efwdRs, act.efwdRt, act.stalls, act.flushes, act.memto,
               e.ctl, e.efwdRs, e.efwdRt, e.stalls, e.flushes, e.memto);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0; applyStimulus("reset", mkExp(NONE, 2'b00, 2'b00, 0, 0, 0));

    clearInputs(); applyStimulus("idle", mkExp(NONE, 2'b00, 2'b00, 0, 0, 0));

    clearInputs(); eMemread = 1; eRegwrite = 1; eRd = 8; dRs = 8; dUseRs = 1;
    applyStimulus("loadUse", mkExp(STALL, 2'b00, 2'b00, 0, 0, 0));

    clearInputs(); mMemread = 1; mRegwrite = 1; mRd = 8; dRs = 8; dUseRs = 1;
    applyStimulus("afterLoad", mkExp(NONE, 2'b00, 2'b00, 1, 1, 0));

    clearInputs(); eRegwrite = 1; eRd = 17; dBranch = 1; dRs = 17; dUseRs = 1;
    applyStimulus("branchVsE", mkExp(STALL, 2'b00, 2'b00, 1, 1, 0));

    clearInputs(); mRegwrite = 1; mRd = 17; dBranch = 1; dRs = 17; dUseRs = 1;
    applyStimulus("branchFwdM", mkExp(DFRS, 2'b00, 2'b00, 2, 2, 0));

    clearInputs(); mRegwrite = 1; mRd = 10; wRegwrite = 1; wRd = 10; eRs = 10; eRt = 10;
    applyStimulus("efwdMoverW", mkExp(NONE, 2'b10, 2'b10, 2, 2, 0));

    clearInputs(); wRegwrite = 1; wRd = 10; eRs = 10; eRt = 5;
    applyStimulus("efwdW", mkExp(NONE, 2'b01, 2'b00, 2, 2, 0));

    clearInputs(); mRegwrite = 1; mMemread = 1; mRd = 10; wRegwrite = 1; wRd = 10; eRs = 10;
    applyStimulus("efwdMloadUsesW", mkExp(NONE, 2'b01, 2'b00, 2, 2, 0));

    clearInputs(); mRegwrite = 1; wRegwrite = 1; eMemread = 1; dUseRs = 1; dUseRt = 1;
    dBranch = 1; eRegwrite = 1;
    applyStimulus("zeroReg", mkExp(NONE, 2'b00, 2'b00, 2, 2, 0));

    clearInputs(); dRedirect = 1;
    applyStimulus("redirect", mkExp(FLUSHD, 2'b00, 2'b00, 2, 2, 0));

    clearInputs(); dRedirect = 1; eMemread = 1; eRd = 8; dRt = 8; dUseRt = 1;
    applyStimulus("redirectHazard", mkExp(STALL, 2'b00, 2'b00, 2, 3, 0));

    clearInputs(); eMemread = 1; eRegwrite = 1; eRd = 8; dBranch = 1; dRs = 8; dUseRs = 1;
    applyStimulus("loadBranch1", mkExp(STALL, 2'b00, 2'b00, 3, 4, 0));
    clearInputs(); mMemread = 1; mRegwrite = 1; mRd = 8; dBranch = 1; dRs = 8; dUseRs = 1;
    applyStimulus("loadBranch2", mkExp(STALL, 2'b00, 2'b00, 4, 5, 0));
    clearInputs(); wRegwrite = 1; wRd = 8; dBranch = 1; dRs = 8; dUseRs = 1;
    applyStimulus("loadBranch3", mkExp(NONE, 2'b00, 2'b00, 5, 6, 0));

    clearInputs(); memReq = 1; dRedirect = 1;
    applyStimulus("freezeReq", mkExp(FRZ, 2'b00, 2'b00, 5, 6, 0));
    clearInputs(); memReq = 1; dRedirect = 1; eMemread = 1; eRd = 8; dRs = 8; dUseRs = 1;
    applyStimulus("freezeOverHazard", mkExp(FRZ, 2'b00, 2'b00, 6, 6, 0));
    clearInputs(); memReq = 1; dRedirect = 1;
    applyStimulus("freezeWait", mkExp(FRZ, 2'b00, 2'b00, 7, 6, 0));
    clearInputs(); memReq = 1; memAck = 1; dRedirect = 1;
    applyStimulus("freezeAck", mkExp(FRZ, 2'b00, 2'b00, 8, 6, 0));
    clearInputs(); dRedirect = 1;
    applyStimulus("redirectAfterFreeze", mkExp(FLUSHD, 2'b00, 2'b00, 9, 6, 0));

    clearInputs(); memReq = 1;
    applyStimulus("toReq", mkExp(FRZ, 2'b00, 2'b00, 9, 7, 0));
    for (int i = 0; i < 5; i++) begin
      clearInputs(); memReq = 1;
      applyStimulus("toWait", mkExp(FRZ, 2'b00, 2'b00, 10 + i, 7, (i == 4)));
    end
    clearInputs(); memReq = 1; memAck = 1;
    applyStimulus("toAckStallSat", mkExp(FRZ, 2'b00, 2'b00, 15, 7, 1));
    clearInputs(); applyStimulus("memtoSticky", mkExp(NONE, 2'b00, 2'b00, 15, 7, 1));
    clearInputs(); eMemread = 1; eRd = 9; dRs = 9; dUseRs = 1;
    applyStimulus("stallHeldSat", mkExp(STALL, 2'b00, 2'b00, 15, 7, 1));
    clearInputs(); applyStimulus("idleSat", mkExp(NONE, 2'b00, 2'b00, 15, 8, 1));

    for (int i = 0; i < 9; i++) begin
      clearInputs(); dRedirect = 1;
      applyStimulus("flushSat", mkExp(FLUSHD, 2'b00, 2'b00, 15, (8 + i > 15) ? 15 : 8 + i, 1));
    end
    clearInputs(); applyStimulus("flushHeldSat", mkExp(NONE, 2'b00, 2'b00, 15, 15, 1));

    clearInputs(); memReq = 1;
    applyStimulus("enterWait", mkExp(FRZ, 2'b00, 2'b00, 15, 15, 1));
    clearInputs(); nrst = 1'b0;
    applyStimulus("resetInWait", mkExp(NONE, 2'b00, 2'b00, 0, 0, 0));
    clearInputs(); applyStimulus("afterReset", mkExp(NONE, 2'b00, 2'b00, 0, 0, 0));
    clearInputs(); dRedirect = 1;
    applyStimulus("redirectPostReset", mkExp(FLUSHD, 2'b00, 2'b00, 0, 0, 0));
    clearInputs(); applyStimulus("countAfterReset", mkExp(NONE, 2'b00, 2'b00, 0, 1, 0));

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: pending=%0d, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
